// File: rtl/fsm_sequencer_if.sv
// fsm_sequencer_if: control, digit-FSM and result signals of the digit-FSM sequencer
interface fsm_sequencer_if;
    logic       start;
    logic       abort;
    logic       step_mode;
    logic       step_req;
    logic       tick;
    logic [3:0] fsm_state;
    logic [3:0] fsm_digit;
    logic       data_in;
    logic       busy;
    logic       done;
    logic       error;
    logic       digit_valid;
    logic [3:0] digit_out;
    logic [3:0] digit_index;
    logic [7:0] digit_sum;
    modport slave (
        input  start, abort, step_mode, step_req, tick, fsm_state, fsm_digit,
        output data_in, busy, done, error, digit_valid, digit_out, digit_index, digit_sum
    );
    modport master (
        output start, abort, step_mode, step_req, tick, fsm_state, fsm_digit,
        input  data_in, busy, done, error, digit_valid, digit_out, digit_index, digit_sum
    );
endinterface

// File: rtl/fsm_sequencer.sv
// fsm_sequencer: walks an external digit FSM through NUM_STATES states, capturing and summing each digit
module fsm_sequencer #(
    parameter int NUM_STATES = 9,
    parameter int HOLD_TICKS = 4
) (
    input logic           clk,
    input logic           reset,
    fsm_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CAPTURE, WAIT, ADVANCE, DONE, ERROR} state_t;
    state_t     state, state_n;
    logic [3:0] count;
    logic [7:0] hold_cnt;
    logic       mode, first, launch, capture, hold_hit;
    logic       valid_q;
    logic [3:0] out_q, idx_q;
    logic [7:0] sum_q;
    always_comb begin
        hold_hit = bus.tick && hold_cnt == 8'(HOLD_TICKS - 1);
        capture  = state == CAPTURE && bus.fsm_state == count && !bus.abort;
        state_n  = state;
        case (state)
            IDLE, ERROR: state_n = bus.start ? CAPTURE : state;
            // digit FSM must have wrapped to state 0 when the walk finishes
            DONE:    state_n = (first && bus.fsm_state != 4'd0) ? ERROR : bus.start ? CAPTURE : DONE;
            CAPTURE: state_n = bus.fsm_state == count ? WAIT : ERROR;
            WAIT:    state_n = (mode ? bus.step_req : hold_hit) ? ADVANCE : WAIT;
            ADVANCE: state_n = count == 4'(NUM_STATES - 1) ? DONE : CAPTURE;
            default: state_n = IDLE;
        endcase
        if (bus.abort) state_n = IDLE;
        launch = state_n == CAPTURE && (state == IDLE || state == DONE || state == ERROR);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            hold_cnt <= 8'd0;
            mode     <= 1'b0;
            first    <= 1'b0;
            valid_q  <= 1'b0;
            out_q    <= 4'd0;
            idx_q    <= 4'd0;
            sum_q    <= 8'd0;
        end else begin
            state   <= state_n;
            first   <= state_n == DONE && state != DONE;
            valid_q <= capture;
            if (launch) begin
                count    <= 4'd0;
                hold_cnt <= 8'd0;
                sum_q    <= 8'd0;
                mode     <= bus.step_mode;
            end
            if (capture) begin
                out_q    <= bus.fsm_digit;
                idx_q    <= count;
                sum_q    <= sum_q + {4'd0, bus.fsm_digit};
                hold_cnt <= 8'd0;
            end
            if (state == WAIT && !mode && bus.tick) hold_cnt <= hold_hit ? 8'd0 : hold_cnt + 8'd1;
            if (state == ADVANCE && !bus.abort) count <= count + 4'd1;
        end
    end
    assign bus.data_in     = state == ADVANCE && !bus.abort;
    assign bus.busy        = state == CAPTURE || state == WAIT || state == ADVANCE;
    assign bus.done        = state == DONE;
    assign bus.error       = state == ERROR;
    assign bus.digit_valid = valid_q;
    assign bus.digit_out   = out_q;
    assign bus.digit_index = idx_q;
    assign bus.digit_sum   = sum_q;
endmodule
